microwave_timer: RTL
====================

Name: microwave_timer

Overview:
- Countdown timer core of the microwave controller.
- Accepts keypad digit entry and start/stop/door events, then counts the cook time down at 1 Hz.
- Drives the BCD digits min / sec_tens / sec_ones consumed directly by the seven-segment decoder stage, plus the magnetron enable and an end-of-cook pulse.

Parameters:
- TICKS_PER_SEC, 50000000: clk cycles per one-second decrement; the bench uses 4.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- digit  input  4  keypad digit value, BCD
- digit_valid  input  1  one-cycle strobe, digit present
- start  input  1  one-cycle strobe, start/resume cooking
- stop_clear  input  1  one-cycle strobe, pause when running, clear when paused/done
- door_open  input  1  level, door open
- min  output  4  minutes digit, BCD 0-9
- sec_tens  output  4  seconds-tens digit, BCD 0-5
- sec_ones  output  4  seconds-ones digit, BCD 0-9
- mag_on  output  1  magnetron enable, high only in RUN
- done  output  1  one-cycle pulse on reaching 0:00 from RUN

Behaviour:
- Reset (async, rst_n low):
  - State SET; min = sec_tens = sec_ones = 0.
  - Prescaler = 0; mag_on = 0; done = 0.
- States: SET, RUN, PAUSE, DONE. All transitions are registered; outputs change on the clock edge after the strobe.
- Priority within a cycle: stop_clear > door_open > start > digit_valid.
- SET:
  - digit_valid with digit <= 9 shifts left: min <= sec_tens, sec_tens <= sec_ones, sec_ones <= digit.
  - The shift is ignored if digit > 9 or sec_ones > 5, because sec_tens must stay 0-5. The old min is discarded.
  - start with door_open = 0 and time != 0:00 enters RUN and clears the prescaler.
  - start with time 0:00 or door open is ignored.
  - stop_clear zeroes all digits.
- RUN:
  - mag_on = 1. The prescaler counts 0..TICKS_PER_SEC-1.
  - On the wrap cycle, decrement once:
    - If sec_ones > 0: sec_ones - 1.
    - Else if sec_tens > 0: sec_ones = 9, sec_tens - 1.
    - Else: min - 1, sec_tens = 5, sec_ones = 9.
  - The first decrement lands exactly TICKS_PER_SEC cycles after the start edge.
  - A decrement that yields 0:00 moves to DONE in the same edge. done = 1 for that one cycle; mag_on = 0 from that edge.
  - door_open = 1 or stop_clear moves to PAUSE and holds the prescaler value. mag_on drops on the same edge.
  - digit_valid and start are ignored.
- PAUSE:
  - Digits and prescaler are frozen.
  - start with door_open = 0 returns to RUN and resumes the prescaler from its held count.
  - stop_clear zeroes the digits and prescaler and enters SET.
  - digit_valid is ignored.
- DONE:
  - Digits read 0:00; mag_on = 0.
  - stop_clear enters SET.
  - A valid digit enters SET and loads the digit as sec_ones in the same edge.
  - start is ignored.
- Digit outputs always hold legal BCD (min 0-9, sec_tens 0-5, sec_ones 0-9). Maximum time is 9:59.
- done never asserts outside the RUN→DONE edge. Reset mid-RUN immediately drops mag_on, with no done pulse.

Test Plan:
- Reset then key 1,3,0 → min=1, sec_tens=3, sec_ones=0. A fourth key 7 → 3:07 (min 1 discarded).
- Key 7 then 8 → second key rejected because sec_ones=7>5 → display 0:07.
- TICKS_PER_SEC=4, load 1:00, start:
  - mag_on=1 next cycle.
  - After 4 cycles → 0:59.
  - After 240 cycles total → 0:00, done pulses one cycle, mag_on=0, state DONE.
- Load 0:05, start, assert door_open after 6 cycles → display 0:04, mag_on=0, frozen while door open. Close door, start → 0:03 after 2 more cycles (prescaler resumed at 2).
- Simultaneous start and stop_clear in SET with 0:30 → digits cleared to 0:00, mag_on stays 0. start with 0:00 → stays in SET.
- Load 0:10, start, pulse rst_n low mid-count (asynchronous, between edges) → all outputs 0 immediately, no done pulse, SET state.

Source files
------------

// File: rtl/microwave_timer.sv
// Countdown timer core of the microwave controller.
// Takes keypad digits and start/stop/door events, counts the cook time
// down once per TICKS_PER_SEC clocks and drives three BCD digits, the
// magnetron enable and a one-cycle end-of-cook pulse.
module microwave_timer #(
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit,
    input  logic       digit_valid,
    input  logic       start,
    input  logic       stop_clear,
    input  logic       door_open,
    output logic [3:0] min,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       mag_on,
    output logic       done
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        ST_SET   = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    min_q, min_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          mag_on_q, mag_on_d;
    logic          done_q, done_d;

    logic          time_nz_s;
    logic          at_one_s;

    // Time-value qualifiers used by the start check and the final decrement.
    always_comb begin
        time_nz_s = (min_q != 4'd0) || (tens_q != 4'd0) || (ones_q != 4'd0);
        at_one_s  = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd1);
    end

    // Next-state logic: event priority is stop_clear > door_open > start > digit_valid.
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        case (state_q)
            ST_SET: begin
                if (stop_clear) begin
                    min_d   = 4'd0;
                    tens_d  = 4'd0;
                    ones_d  = 4'd0;
                    presc_d = {PW{1'b0}};
                end else if (start) begin
                    if (!door_open && time_nz_s) begin
                        state_d = ST_RUN;
                        presc_d = {PW{1'b0}};
                    end else begin
                        state_d = ST_SET;
                    end
                end else if (digit_valid) begin
                    // Shifting is only legal when the old ones digit can become a seconds-tens digit.
                    if ((digit <= 4'd9) && (ones_q <= 4'd5)) begin
                        min_d  = tens_q;
                        tens_d = ones_q;
                        ones_d = digit;
                    end else begin
                        ones_d = ones_q;
                    end
                end else begin
                    state_d = ST_SET;
                end
            end
            ST_RUN: begin
                if (stop_clear || door_open) begin
                    state_d = ST_PAUSE;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = {PW{1'b0}};
                    if (ones_q != 4'd0) begin
                        ones_d = ones_q - 4'd1;
                    end else if (tens_q != 4'd0) begin
                        ones_d = 4'd9;
                        tens_d = tens_q - 4'd1;
                    end else begin
                        min_d  = min_q - 4'd1;
                        tens_d = 4'd5;
                        ones_d = 4'd9;
                    end
                    if (at_one_s) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            ST_PAUSE: begin
                if (stop_clear) begin
                    state_d = ST_SET;
                    min_d   = 4'd0;
                    tens_d  = 4'd0;
                    ones_d  = 4'd0;
                    presc_d = {PW{1'b0}};
                end else if (start && !door_open) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_DONE: begin
                if (stop_clear) begin
                    state_d = ST_SET;
                end else if (digit_valid && (digit <= 4'd9)) begin
                    state_d = ST_SET;
                    ones_d  = digit;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_SET;
                min_d   = 4'd0;
                tens_d  = 4'd0;
                ones_d  = 4'd0;
                presc_d = {PW{1'b0}};
            end
        endcase
        mag_on_d = (state_d == ST_RUN);
    end

    // State, digit, prescaler and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_SET;
            min_q    <= 4'd0;
            tens_q   <= 4'd0;
            ones_q   <= 4'd0;
            presc_q  <= {PW{1'b0}};
            mag_on_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            min_q    <= min_d;
            tens_q   <= tens_d;
            ones_q   <= ones_d;
            presc_q  <= presc_d;
            mag_on_q <= mag_on_d;
            done_q   <= done_d;
        end
    end

    assign min      = min_q;
    assign sec_tens = tens_q;
    assign sec_ones = ones_q;
    assign mag_on   = mag_on_q;
    assign done     = done_q;

endmodule
